// File: rtl/lc3b_perf_counters.sv
// Eight 32-bit event counters behind the 0xFFxx MMIO window, with a shared high-half snapshot.
// Define PERF_SATURATE_EN to make counters stick at 0xFFFF_FFFF instead of wrapping.
module lc3b_perf_counters (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] address,
  input  logic        read,
  input  logic        clear,
  input  logic        ev_cycle,
  input  logic        ev_retire,
  input  logic        ev_l1i_miss,
  input  logic        ev_l1d_miss,
  input  logic        ev_l2_miss,
  input  logic        ev_stall,
  input  logic        ev_branch,
  input  logic        ev_mispredict,
  output logic [15:0] counter_rdata
);

  logic [31:0] cnt_q [8];
  logic [31:0] cnt_d [8];
  logic [15:0] shadow_hi_q;
  logic [15:0] shadow_hi_d;

  logic [7:0]  ev;
  logic        slot_valid;
  logic [2:0]  idx;
  logic        half_hi;
  logic        clr_all;
  logic        unused_addr;

  assign ev = {ev_mispredict, ev_branch, ev_stall, ev_l2_miss,
               ev_l1d_miss, ev_l1i_miss, ev_retire, ev_cycle};

  assign slot_valid  = (address[7:5] == 3'b000);
  assign idx         = address[4:2];
  assign half_hi     = address[1];
  assign clr_all     = (address[7:0] == 8'hFE);
  assign unused_addr = ^{address[15:8], address[0]};

  // High half always comes from the snapshot so a low-then-high pair is coherent.
  always_comb begin
    counter_rdata = 16'h0000;
    if (slot_valid) begin
      if (half_hi) counter_rdata = shadow_hi_q;
      else         counter_rdata = cnt_q[idx][15:0];
    end
  end

  always_comb begin
    shadow_hi_d = shadow_hi_q;
    if (read && slot_valid && !half_hi)
      shadow_hi_d = cnt_q[idx][31:16];
    if (clear && clr_all)
      shadow_hi_d = 16'h0000;
  end

  always_comb begin
    for (int i = 0; i < 8; i++) begin
`ifdef PERF_SATURATE_EN
      if (cnt_q[i] == 32'hFFFF_FFFF) cnt_d[i] = cnt_q[i];
      else                           cnt_d[i] = cnt_q[i] + {31'd0, ev[i]};
`else
      cnt_d[i] = cnt_q[i] + {31'd0, ev[i]};
`endif
      if (clear && ((slot_valid && (idx == 3'(i))) || clr_all))
        cnt_d[i] = 32'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) cnt_q[i] <= 32'd0;
      shadow_hi_q <= 16'h0000;
    end else begin
      for (int i = 0; i < 8; i++) cnt_q[i] <= cnt_d[i];
      shadow_hi_q <= shadow_hi_d;
    end
  end

endmodule

// File: tb/tb_lc3b_perf_counters.sv
// Randomized scoreboard bench for lc3b_perf_counters against an array-based reference model.
module tb_lc3b_perf_counters;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] address;
  logic        read;
  logic        clear;
  logic        ev_cycle, ev_retire, ev_l1i_miss, ev_l1d_miss;
  logic        ev_l2_miss, ev_stall, ev_branch, ev_mispredict;
  logic [15:0] counter_rdata;

  always #5 clk = ~clk;

  lc3b_perf_counters dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .address       (address),
    .read          (read),
    .clear         (clear),
    .ev_cycle      (ev_cycle),
    .ev_retire     (ev_retire),
    .ev_l1i_miss   (ev_l1i_miss),
    .ev_l1d_miss   (ev_l1d_miss),
    .ev_l2_miss    (ev_l2_miss),
    .ev_stall      (ev_stall),
    .ev_branch     (ev_branch),
    .ev_mispredict (ev_mispredict),
    .counter_rdata (counter_rdata)
  );

  typedef struct {
    logic [15:0] addr;
    logic [15:0] exp;
  } exp_t;

  exp_t        sbq[$];
  logic [31:0] m_cnt [8];
  logic [15:0] m_shadow;
  int          n_tests = 0;
  int          n_fail  = 0;

  function automatic logic [15:0] model_read(input logic [15:0] a);
    if (a[7:5] != 3'b000) return 16'h0000;
    if (a[1]) return m_shadow;
    return m_cnt[a[4:2]][15:0];
  endfunction

  task automatic model_clear_all();
    for (int i = 0; i < 8; i++) m_cnt[i] = 32'd0;
    m_shadow = 16'h0000;
  endtask

  task automatic model_step(input logic [15:0] a, input logic rd, input logic clr,
                            input logic [7:0] ev);
    logic [31:0] old [8];
    logic [63:0] sum;
    bit          valid;
    valid = (a[7:5] == 3'b000);
    old = m_cnt;
    if (rd && valid && !a[1]) m_shadow = old[a[4:2]][31:16];
    for (int i = 0; i < 8; i++) begin
      sum = 64'(old[i]) + 64'(ev[i]);
`ifdef PERF_SATURATE_EN
      if (sum > 64'hFFFF_FFFF) sum = 64'hFFFF_FFFF;
`else
      sum = sum % 64'h1_0000_0000;
`endif
      m_cnt[i] = sum[31:0];
    end
    if (clr && valid) m_cnt[a[4:2]] = 32'd0;
    if (clr && a[7:0] == 8'hFE) model_clear_all();
  endtask

  // One bus cycle: drive after the falling edge, queue the expected read data, advance the model at the rising edge.
  task automatic cyc(input logic rst, input logic [15:0] a, input logic rd,
                     input logic clr, input logic [7:0] ev);
    @(negedge clk);
    rst_n   = rst;
    address = a;
    read    = rd;
    clear   = clr;
    {ev_mispredict, ev_branch, ev_stall, ev_l2_miss,
     ev_l1d_miss, ev_l1i_miss, ev_retire, ev_cycle} = ev;
    if (!rst) model_clear_all();
    if (rd) sbq.push_back('{addr: a, exp: model_read(a)});
    @(posedge clk);
    if (rst) model_step(a, rd, clr, ev);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (read) begin
        n_tests++;
        if (sbq.size() == 0) begin
          n_fail++;
          $display("FAIL sb_empty: rdata=%h with no expectation queued", counter_rdata);
        end else begin
          e = sbq.pop_front();
          if (counter_rdata !== e.exp) begin
            n_fail++;
            $display("FAIL read_%h: got %h expected %h at %0t", e.addr, counter_rdata, e.exp, $time);
          end
        end
      end
    end
  end

  function automatic logic [15:0] rand_addr();
    int r;
    r = $urandom_range(0, 9);
    if (r < 7) return {8'hFF, 3'b000, 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
    if (r == 7) return 16'hFFFE;
    return {8'hFF, 8'($urandom_range(0, 255))};
  endfunction

  initial begin : stim
    rst_n = 1'b0; address = 16'hFF00; read = 1'b0; clear = 1'b0;
    {ev_mispredict, ev_branch, ev_stall, ev_l2_miss,
     ev_l1d_miss, ev_l1i_miss, ev_retire, ev_cycle} = 8'h00;
    model_clear_all();

    // Reset held with every event high: all slots read zero.
    for (int k = 0; k < 12; k++)
      cyc(1'b0, {8'hFF, 3'b000, 3'(k % 8), 1'(k / 8), 1'b0}, 1'b1, 1'b0, 8'hFF);
    cyc(1'b1, 16'hFF00, 1'b1, 1'b0, 8'hFF);
    cyc(1'b1, 16'hFF00, 1'b1, 1'b0, 8'hFF);
    cyc(1'b1, 16'hFF1C, 1'b1, 1'b0, 8'h00);

    // Random traffic, including one asynchronous reset pulse mid-run.
    for (int k = 0; k < 3000; k++)
      cyc(k != 1500, rand_addr(), $urandom_range(0, 3) != 0,
          $urandom_range(0, 15) == 0, 8'($urandom));

    // Long run: cycle counter past 2^16, retire counter to exactly 0xFFFF.
    cyc(1'b1, 16'hFFFE, 1'b0, 1'b1, 8'h00);
    for (int k = 0; k < 70000; k++)
      cyc(1'b1, 16'hFF00, 1'b0, 1'b0, {6'd0, k < 65535, 1'b1});
    cyc(1'b1, 16'hFF00, 1'b1, 1'b0, 8'h00);
    cyc(1'b1, 16'hFF02, 1'b1, 1'b0, 8'h00);
    cyc(1'b1, 16'hFF04, 1'b1, 1'b0, 8'h02);
    cyc(1'b1, 16'hFF06, 1'b1, 1'b0, 8'h00);
    cyc(1'b1, 16'hFF04, 1'b1, 1'b0, 8'h00);
    cyc(1'b1, 16'hFF06, 1'b1, 1'b0, 8'h00);

    // Clear beats a same-cycle event; other counters keep counting.
    cyc(1'b1, 16'hFF0C, 1'b0, 1'b1, 8'hFF);
    for (int i = 0; i < 8; i++)
      cyc(1'b1, {8'hFF, 3'b000, 3'(i), 2'b00}, 1'b1, 1'b0, 8'h00);
    // Read and clear together on the same counter show the pre-clear value.
    cyc(1'b1, 16'hFF00, 1'b1, 1'b1, 8'h00);
    cyc(1'b1, 16'hFF00, 1'b1, 1'b0, 8'h00);

    // Invalid slots and a clear at an unmapped address.
    cyc(1'b1, 16'hFF20, 1'b1, 1'b0, 8'h00);
    cyc(1'b1, 16'hFF80, 1'b1, 1'b0, 8'h00);
    cyc(1'b1, 16'hFFFE, 1'b1, 1'b0, 8'h00);
    cyc(1'b1, 16'hFF40, 1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 8; i++)
      cyc(1'b1, {8'hFF, 3'b000, 3'(i), 2'b00}, 1'b1, 1'b0, 8'h00);

    // Clear-all zeroes counters and the snapshot.
    cyc(1'b1, 16'hFF04, 1'b1, 1'b0, 8'h00);
    cyc(1'b1, 16'hFFFE, 1'b0, 1'b1, 8'h00);
    cyc(1'b1, 16'hFF06, 1'b1, 1'b0, 8'h00);
    cyc(1'b1, 16'hFF00, 1'b1, 1'b0, 8'h00);

    cyc(1'b1, 16'hFF00, 1'b0, 1'b0, 8'h00);
    repeat (3) @(negedge clk);
    n_tests++;
    if (sbq.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: %0d expectations left, required 0", sbq.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
